// File: rtl/cp0_core_pkg.sv
// +--------------------------------------------------------------------+
// | cp0_core_pkg: CP0 register addresses, ExcCodes and shared helpers   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cp0_core_pkg;

  // CP0 register selects encoded as {rd[4:0], sel[2:0]}
  typedef enum logic [7:0] {
    CR_INDEX    = 8'h00,
    CR_ENTRYLO0 = 8'h10,
    CR_ENTRYLO1 = 8'h18,
    CR_BADVADDR = 8'h40,
    CR_COUNT    = 8'h48,
    CR_ENTRYHI  = 8'h50,
    CR_COMPARE  = 8'h58,
    CR_STATUS   = 8'h60,
    CR_CAUSE    = 8'h68,
    CR_EPC      = 8'h70
  } cr_addr_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } excode_e;

  localparam logic STATUS_BEV = 1'b1;

  // Address-related exceptions are the only ones that latch BadVAddr
  function automatic logic excode_sets_badvaddr(input logic [4:0] code);
    return (code == EXC_MOD)  || (code == EXC_TLBL) || (code == EXC_TLBS) ||
           (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// +--------------------------------------------------------------------+
// | cp0_timer: Count/Compare pair with half-rate tick and sticky TI     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick    <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (count_we)
        r_count <= wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;
      if (compare_we)
        r_compare <= wdata;
      // A Compare write acknowledges the interrupt even if it matches now
      if (compare_we)
        r_ti <= 1'b0;
      else if (r_count == r_compare)
        r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_core.sv
// +--------------------------------------------------------------------+
// | cp0_core: CP0 register file beside writeback (mtc0/mfc0, exc, TLB)  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cp0_core
  import cp0_core_pkg::*;
#(
  parameter int TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mtc0_we,
  input  logic [7:0]                c0_raddr,
  input  logic [31:0]               c0_wdata,
  input  logic                      wb_bd,
  input  logic                      wb_ex,
  input  logic [4:0]                wb_excode,
  input  logic                      eret_flush,
  input  logic [31:0]               wb_badvaddr,
  input  logic [31:0]               wb_pc,
  output logic [31:0]               rdata,
  output logic [31:0]               c0_epc,
  input  logic [5:0]                ext_int_in,
  output logic                      has_int,
  output logic [31:0]               c0_entryhi,
  output logic [31:0]               c0_entrylo0,
  output logic [31:0]               c0_entrylo1,
  output logic [31:0]               c0_index,
  input  logic                      tlbp,
  input  logic                      tlbp_found,
  input  logic [$clog2(TLBNUM)-1:0] tlbp_index,
  input  logic                      tlbr,
  input  logic [18:0]               r_vpn2,
  input  logic [7:0]                r_asid,
  input  logic                      r_g,
  input  logic [19:0]               r_pfn0,
  input  logic [2:0]                r_c0,
  input  logic                      r_d0,
  input  logic                      r_v0,
  input  logic [19:0]               r_pfn1,
  input  logic [2:0]                r_c1,
  input  logic                      r_d1,
  input  logic                      r_v1
);

  localparam int IDXW = $clog2(TLBNUM);

  logic [7:0]      r_status_im;
  logic            r_status_exl;
  logic            r_status_ie;
  logic            r_cause_bd;
  logic [5:0]      r_cause_ip_hw;
  logic [1:0]      r_cause_ip_sw;
  logic [4:0]      r_cause_excode;
  logic [31:0]     r_epc;
  logic [31:0]     r_badvaddr;
  logic            r_index_p;
  logic [IDXW-1:0] r_index_idx;
  logic [18:0]     r_entryhi_vpn2;
  logic [7:0]      r_entryhi_asid;
  logic [25:0]     r_entrylo0;
  logic [25:0]     r_entrylo1;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic        w_mtc0;
  logic        w_mtc0_ctl;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // Exception commit blocks every mtc0; eret additionally blocks the control regs
  assign w_mtc0     = mtc0_we & ~wb_ex;
  assign w_mtc0_ctl = w_mtc0 & ~eret_flush;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (w_mtc0 && (c0_raddr == CR_COUNT)),
    .compare_we (w_mtc0 && (c0_raddr == CR_COMPARE)),
    .wdata      (c0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status_im    <= 8'd0;
      r_status_exl   <= 1'b0;
      r_status_ie    <= 1'b0;
      r_cause_bd     <= 1'b0;
      r_cause_ip_hw  <= 6'd0;
      r_cause_ip_sw  <= 2'd0;
      r_cause_excode <= 5'd0;
      r_epc          <= 32'd0;
      r_badvaddr     <= 32'd0;
      r_index_p      <= 1'b0;
      r_index_idx    <= '0;
      r_entryhi_vpn2 <= 19'd0;
      r_entryhi_asid <= 8'd0;
      r_entrylo0     <= 26'd0;
      r_entrylo1     <= 26'd0;
    end else begin
      r_cause_ip_hw <= {ext_int_in[5] | w_ti, ext_int_in[4:0]};

      if (wb_ex) begin
        r_status_exl   <= 1'b1;
        r_cause_excode <= wb_excode;
        // Nested exceptions keep the original return point
        if (!r_status_exl) begin
          r_epc      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          r_cause_bd <= wb_bd;
        end
        if (excode_sets_badvaddr(wb_excode))
          r_badvaddr <= wb_badvaddr;
      end else if (eret_flush) begin
        r_status_exl <= 1'b0;
      end else if (w_mtc0_ctl) begin
        if (c0_raddr == CR_STATUS) begin
          r_status_im  <= c0_wdata[15:8];
          r_status_exl <= c0_wdata[1];
          r_status_ie  <= c0_wdata[0];
        end
        if (c0_raddr == CR_CAUSE)
          r_cause_ip_sw <= c0_wdata[9:8];
        if (c0_raddr == CR_EPC)
          r_epc <= c0_wdata;
      end

      if (tlbp) begin
        r_index_p <= ~tlbp_found;
        if (tlbp_found)
          r_index_idx <= tlbp_index;
      end else if (w_mtc0 && (c0_raddr == CR_INDEX)) begin
        r_index_idx <= c0_wdata[IDXW-1:0];
      end

      if (tlbr) begin
        r_entryhi_vpn2 <= r_vpn2;
        r_entryhi_asid <= r_asid;
        r_entrylo0     <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
        r_entrylo1     <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
      end else if (w_mtc0) begin
        if (c0_raddr == CR_ENTRYHI) begin
          r_entryhi_vpn2 <= c0_wdata[31:13];
          r_entryhi_asid <= c0_wdata[7:0];
        end
        if (c0_raddr == CR_ENTRYLO0)
          r_entrylo0 <= c0_wdata[25:0];
        if (c0_raddr == CR_ENTRYLO1)
          r_entrylo1 <= c0_wdata[25:0];
      end
    end
  end

  assign w_status    = {9'd0, STATUS_BEV, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
  assign w_cause     = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw, r_cause_ip_sw, 1'b0,
                        r_cause_excode, 2'd0};
  assign c0_index    = {r_index_p, {(31-IDXW){1'b0}}, r_index_idx};
  assign c0_entryhi  = {r_entryhi_vpn2, 5'd0, r_entryhi_asid};
  assign c0_entrylo0 = {6'd0, r_entrylo0};
  assign c0_entrylo1 = {6'd0, r_entrylo1};
  assign c0_epc      = r_epc;

  assign has_int = (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im)) & r_status_ie & ~r_status_exl;

  always_comb begin
    rdata = 32'd0;
    case (c0_raddr)
      CR_INDEX:    rdata = c0_index;
      CR_ENTRYLO0: rdata = c0_entrylo0;
      CR_ENTRYLO1: rdata = c0_entrylo1;
      CR_BADVADDR: rdata = r_badvaddr;
      CR_COUNT:    rdata = w_count;
      CR_ENTRYHI:  rdata = c0_entryhi;
      CR_COMPARE:  rdata = w_compare;
      CR_STATUS:   rdata = w_status;
      CR_CAUSE:    rdata = w_cause;
      CR_EPC:      rdata = r_epc;
      default:     rdata = 32'd0;
    endcase
  end

endmodule

`default_nettype wire
